// File: rtl/bus_rr_arbiter.sv
// ============================================================================
// Module   : bus_rr_arbiter
// Brief    : Four-master round-robin bus arbiter with hold-time preemption
//            and a slave-ready watchdog; grants are active-low and registered.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int TIMEOUT  = 256,
  parameter int CNT_W    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       s_as_,
  input  logic       m_rdy_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       bus_err,
  output logic [1:0] err_owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_hold_last = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] c_wd_last   = (TIMEOUT == 0)  ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [3:0]       r_grnt_n;
  logic [1:0]       r_last;
  logic [1:0]       r_owner;
  logic [1:0]       r_err_owner;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_wd_cnt;

  logic [3:0] w_req;
  logic       w_any;
  logic [1:0] w_winner;
  logic [1:0] w_idx;
  logic       w_stall;
  logic       w_wd_exp;
  logic       w_owner_req;
  logic       w_others;
  logic       w_preempt;

  assign w_req = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign w_any = |w_req;

  // Scan farthest-first so the master nearest after r_last overwrites the rest.
  always_comb begin
    w_winner = r_last;
    w_idx    = r_last;
    for (int i = 4; i >= 1; i--) begin
      w_idx = r_last + i[1:0];
      if (w_req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  assign w_stall     = ~s_as_ & m_rdy_;
  assign w_wd_exp    = (TIMEOUT != 0) && w_stall && (r_wd_cnt == c_wd_last);
  assign w_owner_req = w_req[r_owner];
  assign w_others    = |(w_req & ~(4'b0001 << r_owner));
  assign w_preempt   = (MAX_HOLD != 0) && (r_hold_cnt >= c_hold_last) && w_others && s_as_;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_grnt_n    <= 4'hF;
      r_last      <= 2'd3;
      r_owner     <= 2'd0;
      r_err_owner <= 2'd0;
      r_bus_err   <= 1'b0;
      r_hold_cnt  <= '0;
      r_wd_cnt    <= '0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_OWNED;
            r_grnt_n   <= ~(4'b0001 << w_winner);
            r_owner    <= w_winner;
            r_hold_cnt <= '0;
            r_wd_cnt   <= '0;
          end
        end
        ST_OWNED: begin
          if (w_stall) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end else begin
            r_wd_cnt <= '0;
          end
          // Watchdog outranks release, which outranks preemption.
          if (w_wd_exp) begin
            r_state     <= ST_ERR;
            r_grnt_n    <= 4'hF;
            r_bus_err   <= 1'b1;
            r_err_owner <= r_owner;
            r_last      <= r_owner;
            r_wd_cnt    <= r_wd_cnt;
          end else if (!w_owner_req || w_preempt) begin
            r_state  <= ST_IDLE;
            r_grnt_n <= 4'hF;
            r_last   <= r_owner;
          end else if (r_hold_cnt < c_hold_last) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_grnt_n <= 4'hF;
        end
      endcase
    end
  end

  assign m0_grnt_  = r_grnt_n[0];
  assign m1_grnt_  = r_grnt_n[1];
  assign m2_grnt_  = r_grnt_n[2];
  assign m3_grnt_  = r_grnt_n[3];
  assign owner     = r_owner;
  assign bus_err   = r_bus_err;
  assign err_owner = r_err_owner;

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
// ============================================================================
// Module   : tb_bus_rr_arbiter
// Brief    : Directed bench for bus_rr_arbiter against a cycle-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_rr_arbiter;

  localparam int MAX_HOLD = 16;
  localparam int TIMEOUT  = 256;
  localparam int CNT_W    = 9;
  localparam int P_IDLE   = 0;
  localparam int P_OWNED  = 1;
  localparam int P_ERR    = 2;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic [3:0] req_n  = 4'hF;
  logic       s_as_  = 1'b1;
  logic       m_rdy_ = 1'b1;
  logic       g0, g1, g2, g3;
  logic [3:0] grnt_n;
  logic [1:0] owner, err_owner;
  logic       bus_err;

  int vectors    = 0;
  int miscompares = 0;

  bus_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req_   (req_n[0]),
    .m1_req_   (req_n[1]),
    .m2_req_   (req_n[2]),
    .m3_req_   (req_n[3]),
    .s_as_     (s_as_),
    .m_rdy_    (m_rdy_),
    .m0_grnt_  (g0),
    .m1_grnt_  (g1),
    .m2_grnt_  (g2),
    .m3_grnt_  (g3),
    .owner     (owner),
    .bus_err   (bus_err),
    .err_owner (err_owner)
  );

  assign grnt_n = {g3, g2, g1, g0};

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         md_phase = P_IDLE;
  int         md_own   = 0;
  int         md_last  = 3;
  int         md_held  = 0;
  int         md_stall = 0;
  logic [1:0] md_owner_out = 2'd0;
  logic [1:0] md_err_owner = 2'd0;

  function automatic int pick(input logic [3:0] rq, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (rq[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    md_phase     = P_IDLE;
    md_own       = 0;
    md_last      = 3;
    md_held      = 0;
    md_stall     = 0;
    md_owner_out = 2'd0;
    md_err_owner = 2'd0;
  endtask

  task automatic model_step();
    logic [3:0] rq;
    bit         stalled;
    bit         others;
    int         w;
    rq      = ~req_n;
    stalled = !s_as_ && m_rdy_;
    case (md_phase)
      P_IDLE: begin
        w = pick(rq, md_last);
        if (w >= 0) begin
          md_phase     = P_OWNED;
          md_own       = w;
          md_owner_out = 2'(w);
          md_held      = 0;
          md_stall     = 0;
        end
      end
      P_OWNED: begin
        others = (rq & ~(4'b0001 << md_own)) != 4'b0;
        if (stalled && TIMEOUT != 0 && md_stall + 1 == TIMEOUT) begin
          md_phase     = P_ERR;
          md_err_owner = 2'(md_own);
          md_last      = md_own;
        end else if (!rq[md_own]) begin
          md_phase = P_IDLE;
          md_last  = md_own;
        end else if (MAX_HOLD != 0 && md_held + 1 >= MAX_HOLD && others && s_as_) begin
          md_phase = P_IDLE;
          md_last  = md_own;
        end else begin
          md_held++;
        end
        md_stall = stalled ? md_stall + 1 : 0;
      end
      default: md_phase = P_IDLE;
    endcase
  endtask

  always @(posedge clk) begin
    if (!reset) model_reset();
    else        model_step();
  end

  always @(negedge reset) model_reset();

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("grnt_n", int'(grnt_n),
        (md_phase == P_OWNED) ? int'(~(4'b0001 << md_own) & 4'hF) : 15);
    chk("owner", int'(owner), int'(md_owner_out));
    chk("bus_err", int'(bus_err), (md_phase == P_ERR) ? 1 : 0);
    chk("err_owner", int'(err_owner), int'(md_err_owner));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int k, input int budget);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << k);
    n = 0;
    while (grnt_n != want && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("grant_m%0d_within_%0d", k, budget), int'(grnt_n), int'(want));
  endtask

  task automatic count_hold(input logic [3:0] held_pat, input int as_lo, input int as_hi,
                            output int t);
    t = 0;
    while (grnt_n == held_pat && t < 100) begin
      s_as_ = (t >= as_lo && t <= as_hi) ? 1'b0 : 1'b1;
      tick();
      t++;
    end
    s_as_ = 1'b1;
  endtask

  initial begin
    int t;
    int errs_seen;

    repeat (3) tick();
    chk("reset_grnt", int'(grnt_n), 15);
    chk("reset_bus_err", int'(bus_err), 0);
    chk("reset_err_owner", int'(err_owner), 0);

    // 1: all masters request at release; grant rotates 0,1,2,3
    reset = 1'b1;
    req_n = 4'b0000;
    tick();
    chk("first_grant_m0", int'(grnt_n), 4'hE);
    req_n[0] = 1'b1;
    for (int k = 1; k < 4; k++) begin
      wait_grant(k, 3);
      req_n[k] = 1'b1;
    end
    repeat (2) tick();

    // 2: m1 hogs with s_as_ high, m2 waiting -> preempted after 16 cycles
    req_n = 4'b1001;
    wait_grant(1, 3);
    count_hold(4'b1101, 1000, 1000, t);
    chk("hold_cycles_free", t, 16);
    chk("dead_cycle_preempt", int'(grnt_n), 15);
    tick();
    chk("m2_after_preempt", int'(grnt_n), 4'hB);
    req_n = 4'hF;
    repeat (2) tick();

    // 3: same, but a transfer is in flight over the hold limit
    req_n = 4'b1001;
    wait_grant(1, 3);
    count_hold(4'b1101, 12, 20, t);
    chk("hold_cycles_busy", t, 22);
    tick();
    chk("m2_after_busy_preempt", int'(grnt_n), 4'hB);
    req_n = 4'hF;
    repeat (2) tick();

    // 4: m0 stuck on an unready slave; m1 waiting
    req_n = 4'b1110;
    wait_grant(0, 3);
    s_as_ = 1'b0;
    req_n = 4'b1100;
    t = 0;
    while (!bus_err && t < 400) begin
      tick();
      t++;
    end
    chk("wd_latency", t, 256);
    chk("wd_err_owner", int'(err_owner), 0);
    chk("wd_grants_dropped", int'(grnt_n), 15);
    s_as_ = 1'b1;
    req_n = 4'b1101;
    tick();
    chk("bus_err_one_cycle", int'(bus_err), 0);
    tick();
    chk("m1_after_err", int'(grnt_n), 4'hD);

    // watchdog restarts on every ready; never expires here
    s_as_ = 1'b0;
    errs_seen = 0;
    for (int c = 0; c < 300; c++) begin
      m_rdy_ = (c % 50 == 49) ? 1'b0 : 1'b1;
      tick();
      if (bus_err) errs_seen++;
    end
    chk("wd_cleared_by_rdy", errs_seen, 0);
    s_as_  = 1'b1;
    m_rdy_ = 1'b1;
    req_n  = 4'hF;
    repeat (2) tick();

    // 5: m3 releases in the very cycle the watchdog fires
    req_n = 4'b0111;
    wait_grant(3, 3);
    s_as_ = 1'b0;
    t = 0;
    while (!bus_err && t < 400) begin
      if (t == 255) req_n = 4'b1010;
      tick();
      t++;
    end
    chk("wd_vs_release_latency", t, 256);
    chk("wd_vs_release_err_owner", int'(err_owner), 3);
    s_as_ = 1'b1;
    repeat (2) tick();
    chk("m0_after_m3_err", int'(grnt_n), 4'hE);

    // 6: reset mid-transfer
    req_n = 4'b1101;
    wait_grant(1, 4);
    s_as_ = 1'b0;
    repeat (3) tick();
    #3 reset = 1'b0;
    #1;
    chk("async_reset_grnt", int'(grnt_n), 15);
    chk("async_reset_bus_err", int'(bus_err), 0);
    chk("async_reset_owner", int'(owner), 0);
    repeat (2) tick();
    reset = 1'b1;
    req_n = 4'hF;
    s_as_ = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
